// File: rtl/helix_reg_arbiter.sv
// Round-robin arbiter sharing one 16-bit register bus between two masters, one transaction
// in flight. Read timeout path is built only when HELIX_REG_ARB_TIMEOUT_EN is defined.
module helix_reg_arbiter #(
  parameter logic [15:0] TIMEOUT_CYCLES = 16'd255,
  parameter logic [15:0] TIMEOUT_DATA   = 16'hDEAD
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        m0_en_i,
  input  logic        m0_wr_i,
  input  logic        m0_update_i,
  input  logic [15:0] m0_adr_i,
  input  logic [15:0] m0_dat_i,
  output logic        m0_ack_o,
  input  logic        m1_en_i,
  input  logic        m1_wr_i,
  input  logic        m1_update_i,
  input  logic [15:0] m1_adr_i,
  input  logic [15:0] m1_dat_i,
  output logic        m1_ack_o,
  output logic [15:0] m_dat_o,
  output logic        m_err_o,
  output logic        reg_en_o,
  output logic        reg_wr_o,
  output logic        reg_update_o,
  output logic [15:0] reg_adr_o,
  output logic [15:0] reg_dat_o,
  input  logic [15:0] reg_dat_i,
  input  logic        reg_valid_i,
  output logic        busy_o
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StAck} state_e;

  state_e      state_q, state_d;
  logic        grant_q, grant_d;
  logic        last_grant_q, last_grant_d;
  logic        wr_q, wr_d;
  logic        update_q, update_d;
  logic        err_q, err_d;
  logic [15:0] adr_q, adr_d;
  logic [15:0] dat_q, dat_d;
  logic [15:0] rdata_q, rdata_d;
  logic        sel;
  logic        timeout;

`ifdef HELIX_REG_ARB_TIMEOUT_EN
  // A zero budget behaves like a single WAIT cycle.
  localparam logic [15:0] TimeoutLast =
      (TIMEOUT_CYCLES == 16'd0) ? 16'd0 : TIMEOUT_CYCLES - 16'd1;

  logic [15:0] tcnt_q, tcnt_d;

  always_comb begin
    tcnt_d = tcnt_q;
    if (state_q == StIssue) begin
      tcnt_d = '0;
    end else if (state_q == StWait) begin
      tcnt_d = tcnt_q + 16'd1;
    end
  end

  assign timeout = (state_q == StWait) && (tcnt_q == TimeoutLast);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      tcnt_q <= '0;
    end else begin
      tcnt_q <= tcnt_d;
    end
  end
`else
  logic unused_timeout_params;
  assign unused_timeout_params = ^{TIMEOUT_CYCLES, TIMEOUT_DATA};
  assign timeout = 1'b0;
`endif

  // On a tie the master that was not served last wins.
  always_comb begin
    sel = m1_en_i;
    if (m0_en_i && m1_en_i) begin
      sel = ~last_grant_q;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    wr_d         = wr_q;
    update_d     = update_q;
    err_d        = err_q;
    adr_d        = adr_q;
    dat_d        = dat_q;
    rdata_d      = rdata_q;
    unique case (state_q)
      StIdle: begin
        if (m0_en_i || m1_en_i) begin
          grant_d  = sel;
          wr_d     = sel ? m1_wr_i : m0_wr_i;
          update_d = sel ? (m1_wr_i & m1_update_i) : (m0_wr_i & m0_update_i);
          adr_d    = sel ? m1_adr_i : m0_adr_i;
          dat_d    = sel ? m1_dat_i : m0_dat_i;
          rdata_d  = '0;
          err_d    = 1'b0;
          state_d  = StIssue;
        end
      end
      StIssue: begin
        if (wr_q) begin
          state_d = StAck;
        end else if (reg_valid_i) begin
          rdata_d = reg_dat_i;
          state_d = StAck;
        end else begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (reg_valid_i) begin
          rdata_d = reg_dat_i;
          state_d = StAck;
        end else if (timeout) begin
`ifdef HELIX_REG_ARB_TIMEOUT_EN
          rdata_d = TIMEOUT_DATA;
`endif
          err_d   = 1'b1;
          state_d = StAck;
        end
      end
      StAck: begin
        last_grant_d = grant_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_q      <= StIdle;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wr_q         <= 1'b0;
      update_q     <= 1'b0;
      err_q        <= 1'b0;
      adr_q        <= '0;
      dat_q        <= '0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      wr_q         <= wr_d;
      update_q     <= update_d;
      err_q        <= err_d;
      adr_q        <= adr_d;
      dat_q        <= dat_d;
      rdata_q      <= rdata_d;
    end
  end

  assign reg_en_o     = (state_q == StIssue) || (state_q == StWait);
  assign reg_wr_o     = (state_q == StIssue) && wr_q;
  assign reg_update_o = (state_q == StIssue) && update_q;
  assign reg_adr_o    = adr_q;
  assign reg_dat_o    = dat_q;
  assign m0_ack_o     = (state_q == StAck) && !grant_q;
  assign m1_ack_o     = (state_q == StAck) && grant_q;
  assign m_dat_o      = (state_q == StAck) ? rdata_q : 16'h0000;
  assign m_err_o      = (state_q == StAck) && err_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: doc/helix_reg_arbiter.md
# helix_reg_arbiter

Two-master arbiter sharing one 16-bit register bus (reg_en/reg_wr/reg_update/reg_adr/reg_dat/reg_valid) between the HELIX control-packet decoder and a local requester (bootloader/sequencer). Round-robin grant, one transaction in flight, registered downstream outputs, optional read timeout so a silent slave cannot hang the control path.

## Interface
- TIMEOUT_CYCLES, 16'd255: WAIT-state cycles before a read is force-completed (timeout build only).
- TIMEOUT_DATA, 16'hDEAD: read data returned on timeout.
- aclk  in  1  clock, all logic on rising edge.
- aresetn  in  1  reset, asynchronous, active-low.
- mN_en_i (N=0,1)  in  1  request; held high with mN_* fields stable until mN_ack_o.
- mN_wr_i  in  1  1 = write, 0 = read.
- mN_update_i  in  1  update qualifier, meaningful only with mN_wr_i=1.
- mN_adr_i  in  16  register address.
- mN_dat_i  in  16  write data.
- mN_ack_o  out  1  one-cycle completion pulse to requester N.
- m_dat_o  out  16  read data, shared, valid in ack cycle (writes: 0).
- m_err_o  out  1  high in ack cycle if read timed out.
- reg_en_o  out  1  downstream transaction enable.
- reg_wr_o  out  1  downstream write strobe.
- reg_update_o  out  1  downstream update strobe.
- reg_adr_o  out  16  downstream address.
- reg_dat_o  out  16  downstream write data.
- reg_dat_i  in  16  downstream read data, sampled when reg_valid_i=1.
- reg_valid_i  in  1  downstream read completion.
- busy_o  out  1  high in any state other than IDLE.

## Operation
- States: IDLE, ISSUE, WAIT, ACK.
- IDLE: if any mN_en_i, pick grant; latch adr/dat/wr/update(=wr&update) of winner; -> ISSUE.
- Arbitration: single request wins; both requesting -> requester != last_grant. last_grant resets to 1 (master 0 wins first tie), updated in ACK.
- ISSUE: reg_en_o=1, reg_wr_o=wr, reg_update_o=update. Write -> ACK. Read with reg_valid_i=1 -> capture reg_dat_i, ACK; else -> WAIT.
- WAIT: reg_en_o=1, reg_wr_o=reg_update_o=0. reg_valid_i=1 -> capture, ACK. Timeout (see Configuration) -> data=TIMEOUT_DATA, err=1, ACK.
- ACK: mN_ack_o=1 for granted N only; m_dat_o/m_err_o valid; -> IDLE.
- reg_adr_o/reg_dat_o hold latched values from ISSUE until next grant.
- reg_valid_i ignored outside ISSUE/WAIT and for writes.
- Requester deasserting mN_en_i mid-transaction: ignored; transaction completes, ack still issued.
- Reset mid-transaction: immediate return to IDLE, transaction dropped, no ack.

## Timing
- All outputs registered or decoded from registered state; no input-to-output combinational path.
- Reset values: every output 0, state IDLE, latched fields 0, last_grant=1, timeout counter 0.
- Write: request sampled edge 0 -> reg_en_o/reg_wr_o high cycle 1 -> ack cycle 2 -> IDLE cycle 3. Three cycles per write.
- Read, reg_valid_i in ISSUE: ack cycle 2. Each extra cycle of reg_valid_i low adds one cycle.
- Back-to-back: requester holding mN_en_i after ack is sampled again in IDLE; with both requesting, grants alternate.
- Timeout counter: 16-bit, cleared in ISSUE, increments each WAIT cycle; timeout when count == TIMEOUT_CYCLES-1 (WAIT lasts exactly TIMEOUT_CYCLES cycles). TIMEOUT_CYCLES=0 treated as 1.

## Configuration
- HELIX_REG_ARB_TIMEOUT_EN defined: timeout counter and TIMEOUT_DATA path built as above.
- Undefined: no counter; WAIT exits only on reg_valid_i; m_err_o tied 0; TIMEOUT_* parameters unused.

## Test plan
- Master 0 write adr 16'h0012 dat 16'hBEEF -> reg_en_o+reg_wr_o cycle 1 with those values, m0_ack_o cycle 2, m1_ack_o never.
- Master 1 read adr 16'h0100, reg_valid_i after 3 WAIT cycles with reg_dat_i 16'h1234 -> m1_ack_o with m_dat_o 16'h1234, m_err_o 0.
- Both hold reads continuously from reset -> grants alternate 0,1,0,1; no ack lost.
- Master 0 write with update=1 -> reg_update_o high cycle 1; read with update=1 -> reg_update_o stays 0.
- Timeout build, TIMEOUT_CYCLES=4, reg_valid_i never -> ack after 4 WAIT cycles, m_dat_o 16'hDEAD, m_err_o 1; non-timeout build stays in WAIT.
- aresetn low in WAIT -> all outputs 0 immediately, no ack; after release master 0 wins tie.
